cpu_run_monitor: RTL and testbench
==================================

Name: cpu_run_monitor

Overview:
Synthesizable run-control and result-dump block for multi-core processor tiles.
- Watches each core's fetched instruction word and counts cycles per core until the halt word appears.
- Once every enabled core has halted, waits a fixed pipeline-flush interval.
- Then reads DUMP_WORDS data-memory words per core through a shared read port and streams them out on a valid/ready interface.

Parameters:
NUM_CORES, 1, number of monitored cores/channels
INST_W, 32, instruction word width
DATA_W, 64, data-memory word width
ADDR_W, 32, data-memory address width
CNT_W, 32, cycle-counter width
HALT_INST, 0, instruction value that marks program completion
FLUSH_CYCLES, 5, idle cycles between all-halted and first dump read (0 allowed)
DUMP_WORDS, 128, words dumped per core, addresses 0..DUMP_WORDS-1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
core_en  in  NUM_CORES  per-core enable; captured every cycle reset is high, ignored otherwise
inst_in  in  NUM_CORES*INST_W  per-core fetched instruction, core c in slice c
cycle_count  out  NUM_CORES*CNT_W  per-core cycle count, frozen at halt
halted  out  NUM_CORES  sticky per-core halt flags
mem_rd_en  out  1  one-cycle read strobe to data memory
mem_core_sel  out  log2(NUM_CORES) min 1  core whose memory is read
mem_addr  out  ADDR_W  word address
mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
dump_valid  out  1  dump word available
dump_ready  in  1  consumer accepts word
dump_data  out  DATA_W  dumped word
dump_core  out  log2(NUM_CORES) min 1  source core of dump_data
dump_index  out  ADDR_W  address of dump_data
done  out  1  sticky; all dumping finished

Behaviour:
- Reset: every output is 0. All counters and halted flags are cleared. State = RUN. An enable mask is latched from core_en. Reset asserted in any state aborts immediately, including mid-dump with dump_valid high.
- States: RUN, FLUSH, RD, WAIT, OUT, DONE.
- RUN:
  - Each cycle, each enabled, not-halted core c samples inst_in slice c.
  - If the slice equals HALT_INST, halted[c] is set and the counter does not increment that cycle. Otherwise cycle_count[c] increments by 1.
  - Counters saturate at all ones with no wrap.
  - Disabled cores read halted=1 and count 0.
  - Several cores may halt in the same cycle.
  - When all halted bits are 1 -> FLUSH. This happens on the first cycle after reset if no core is enabled.
- FLUSH: stays exactly FLUSH_CYCLES cycles, then -> RD. FLUSH_CYCLES=0 means it goes directly to RD on the next cycle.
- Dump order: enabled cores ascending, disabled cores skipped. Within each core, index 0..DUMP_WORDS-1. If no core is enabled, RUN -> FLUSH -> DONE with no reads.
- RD:
  - mem_rd_en=1 for one cycle, with mem_core_sel=core and mem_addr=index.
  - -> WAIT.
  - mem_rd_en is 0 in every other state.
- WAIT: capture mem_rd_data into dump_data, load dump_core and dump_index, -> OUT.
- OUT:
  - dump_valid=1; data, core and index are held stable until dump_ready=1.
  - On the handshake cycle (valid and ready both 1): advance index/core.
  - If words remain -> RD, else -> DONE.
  - dump_valid drops the cycle after the handshake.
  - Minimum 3 cycles per word. Exactly one read is outstanding at a time.
- DONE: done=1. halted and cycle_count are held. dump_valid=0. Stays here until reset.
- inst_in is ignored outside RUN. Halted flags never clear except on reset.

Test Plan:
- NUM_CORES=1, inst_in nonzero for 10 cycles after reset, then 0 -> cycle_count=10, halted=1. First mem_rd_en occurs FLUSH_CYCLES+1 cycles after halt sampled. With dump_ready=1: 128 words with dump_index 0..127 matching a preloaded memory model, then done=1.
- dump_ready held 0 for 7 cycles on word 5 -> dump_valid, dump_data and dump_index=5 stable all 7 cycles. No new mem_rd_en until handshake. No word lost or duplicated.
- NUM_CORES=4, core_en=4'b1011, cores halt at cycles 3, 20 and 8 -> counts 3, 20, 0 and 8, with the disabled core reading count 0. Dump sequence: core 0, then core 1, then core 3; core 2 skipped. Total 384 words.
- CNT_W=4, halt at cycle 30 -> cycle_count saturates at 15.
- core_en all zero -> no mem_rd_en ever. done=1 at FLUSH_CYCLES+2 cycles after reset release.
- reset pulsed during OUT -> next cycle all outputs 0 and state RUN. Counting restarts from 0 on rerun.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// Run-control monitor: counts cycles per core until the halt word is fetched, waits a flush
// interval once all enabled cores are halted, then streams each enabled core's data memory out.
module cpu_run_monitor #(
  parameter int unsigned        NUM_CORES    = 1,
  parameter int unsigned        INST_W       = 32,
  parameter int unsigned        DATA_W       = 64,
  parameter int unsigned        ADDR_W       = 32,
  parameter int unsigned        CNT_W        = 32,
  parameter logic [INST_W-1:0]  HALT_INST    = '0,
  parameter int unsigned        FLUSH_CYCLES = 5,
  parameter int unsigned        DUMP_WORDS   = 128,
  localparam int unsigned       SEL_W        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          core_en,
  input  logic [NUM_CORES*INST_W-1:0]   inst_in,
  output logic [NUM_CORES*CNT_W-1:0]    cycle_count,
  output logic [NUM_CORES-1:0]          halted,
  output logic                          mem_rd_en,
  output logic [SEL_W-1:0]              mem_core_sel,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_rd_data,
  output logic                          dump_valid,
  input  logic                          dump_ready,
  output logic [DATA_W-1:0]             dump_data,
  output logic [SEL_W-1:0]              dump_core,
  output logic [ADDR_W-1:0]             dump_index,
  output logic                          done
);

  typedef enum logic [2:0] {StRun, StFlush, StRd, StWait, StOut, StDone} state_e;

  state_e                          state_q, state_d;
  logic [NUM_CORES-1:0]            en_mask_q;
  logic [NUM_CORES-1:0]            halted_q, halted_d;
  logic [NUM_CORES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]                     flush_cnt_q, flush_cnt_d;
  logic [SEL_W-1:0]                core_q, core_d;
  logic [ADDR_W-1:0]               idx_q, idx_d;
  logic [DATA_W-1:0]               dump_data_q, dump_data_d;
  logic [SEL_W-1:0]                dump_core_q, dump_core_d;
  logic [ADDR_W-1:0]               dump_index_q, dump_index_d;

  logic                            first_found, next_found;
  logic [SEL_W-1:0]                first_core, next_core;

  // Lowest enabled core overall, and lowest enabled core above the one being dumped.
  always_comb begin
    first_found = 1'b0;
    first_core  = '0;
    next_found  = 1'b0;
    next_core   = '0;
    for (int c = int'(NUM_CORES) - 1; c >= 0; c--) begin
      if (en_mask_q[c]) begin
        first_found = 1'b1;
        first_core  = SEL_W'(c);
        if (c > int'(core_q)) begin
          next_found = 1'b1;
          next_core  = SEL_W'(c);
        end
      end
    end
  end

  always_comb begin
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (state_q == StRun) begin
      for (int c = 0; c < int'(NUM_CORES); c++) begin
        if (!en_mask_q[c]) begin
          halted_d[c] = 1'b1;
        end else if (!halted_q[c]) begin
          if (inst_in[c*INST_W +: INST_W] == HALT_INST) begin
            halted_d[c] = 1'b1;
          end else if (cnt_q[c] != '1) begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    core_d       = core_q;
    idx_d        = idx_q;
    dump_data_d  = dump_data_q;
    dump_core_d  = dump_core_q;
    dump_index_d = dump_index_q;
    unique case (state_q)
      StRun: begin
        if (&halted_q) begin
          core_d      = first_core;
          idx_d       = '0;
          flush_cnt_d = '0;
          if (FLUSH_CYCLES != 0) begin
            state_d = StFlush;
          end else begin
            state_d = first_found ? StRd : StDone;
          end
        end
      end
      StFlush: begin
        if (flush_cnt_q == FLUSH_CYCLES - 1) begin
          state_d = first_found ? StRd : StDone;
        end else begin
          flush_cnt_d = flush_cnt_q + 32'd1;
        end
      end
      StRd: state_d = StWait;
      StWait: begin
        dump_data_d  = mem_rd_data;
        dump_core_d  = core_q;
        dump_index_d = idx_q;
        state_d      = StOut;
      end
      StOut: begin
        if (dump_ready) begin
          if (idx_q == ADDR_W'(DUMP_WORDS - 1)) begin
            idx_d = '0;
            if (next_found) begin
              core_d  = next_core;
              state_d = StRd;
            end else begin
              state_d = StDone;
            end
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = StRd;
          end
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      en_mask_q    <= core_en;
      halted_q     <= '0;
      cnt_q        <= '0;
      flush_cnt_q  <= '0;
      core_q       <= '0;
      idx_q        <= '0;
      dump_data_q  <= '0;
      dump_core_q  <= '0;
      dump_index_q <= '0;
    end else begin
      state_q      <= state_d;
      halted_q     <= halted_d;
      cnt_q        <= cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      core_q       <= core_d;
      idx_q        <= idx_d;
      dump_data_q  <= dump_data_d;
      dump_core_q  <= dump_core_d;
      dump_index_q <= dump_index_d;
    end
  end

  assign cycle_count  = cnt_q;
  assign halted       = halted_q;
  assign mem_rd_en    = (state_q == StRd);
  assign mem_core_sel = core_q;
  assign mem_addr     = idx_q;
  assign dump_valid   = (state_q == StOut);
  assign dump_data    = dump_data_q;
  assign dump_core    = dump_core_q;
  assign dump_index   = dump_index_q;
  assign done         = (state_q == StDone);

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: single core, four cores with one disabled, and a
// narrow-counter / zero-flush configuration, each against a registered memory model.
module tb_cpu_run_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n;
  int rd0;
  int dsel;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] mem_word(input int core, input int idx);
    return (64'(core) << 56) ^ (64'(idx) * 64'h0000_0001_0001_0003) ^ 64'hDEAD_0000_BEEF_0000;
  endfunction

  // DUT A: defaults, one core
  logic        reset_a, core_en_a, halted_a, rd_en_a, valid_a, ready_a, done_a;
  logic [31:0] inst_a, cc_a, addr_a, index_a;
  logic [0:0]  sel_a, core_a;
  logic [63:0] rd_data_a, data_a;
  int          rd_cnt_a = 0;

  cpu_run_monitor dut_a (
    .clk(clk), .reset(reset_a), .core_en(core_en_a), .inst_in(inst_a), .cycle_count(cc_a),
    .halted(halted_a), .mem_rd_en(rd_en_a), .mem_core_sel(sel_a), .mem_addr(addr_a),
    .mem_rd_data(rd_data_a), .dump_valid(valid_a), .dump_ready(ready_a), .dump_data(data_a),
    .dump_core(core_a), .dump_index(index_a), .done(done_a)
  );

  // DUT B: four cores
  logic         reset_b, rd_en_b, valid_b, ready_b, done_b;
  logic [3:0]   core_en_b, halted_b;
  logic [127:0] inst_b, cc_b;
  logic [31:0]  addr_b, index_b;
  logic [1:0]   sel_b, core_b;
  logic [63:0]  rd_data_b, data_b;
  int           rd_cnt_b = 0;

  cpu_run_monitor #(.NUM_CORES(4)) dut_b (
    .clk(clk), .reset(reset_b), .core_en(core_en_b), .inst_in(inst_b), .cycle_count(cc_b),
    .halted(halted_b), .mem_rd_en(rd_en_b), .mem_core_sel(sel_b), .mem_addr(addr_b),
    .mem_rd_data(rd_data_b), .dump_valid(valid_b), .dump_ready(ready_b), .dump_data(data_b),
    .dump_core(core_b), .dump_index(index_b), .done(done_b)
  );

  // DUT C: 4-bit counter, no flush interval, short dump
  logic        reset_c, core_en_c, halted_c, rd_en_c, valid_c, ready_c, done_c;
  logic [31:0] inst_c, addr_c, index_c;
  logic [3:0]  cc_c;
  logic [0:0]  sel_c, core_c;
  logic [63:0] rd_data_c, data_c;
  int          rd_cnt_c = 0;

  cpu_run_monitor #(.CNT_W(4), .FLUSH_CYCLES(0), .DUMP_WORDS(4)) dut_c (
    .clk(clk), .reset(reset_c), .core_en(core_en_c), .inst_in(inst_c), .cycle_count(cc_c),
    .halted(halted_c), .mem_rd_en(rd_en_c), .mem_core_sel(sel_c), .mem_addr(addr_c),
    .mem_rd_data(rd_data_c), .dump_valid(valid_c), .dump_ready(ready_c), .dump_data(data_c),
    .dump_core(core_c), .dump_index(index_c), .done(done_c)
  );

  // Memory models: data valid only in the cycle after the strobe, junk otherwise
  always @(posedge clk) begin
    if (rd_en_a) begin
      rd_data_a <= mem_word(int'(sel_a), int'(addr_a));
      rd_cnt_a  <= rd_cnt_a + 1;
    end else rd_data_a <= 64'h0BAD_0BAD_0BAD_0BAD;
    if (rd_en_b) begin
      rd_data_b <= mem_word(int'(sel_b), int'(addr_b));
      rd_cnt_b  <= rd_cnt_b + 1;
    end else rd_data_b <= 64'h0BAD_0BAD_0BAD_0BAD;
    if (rd_en_c) begin
      rd_data_c <= mem_word(int'(sel_c), int'(addr_c));
      rd_cnt_c  <= rd_cnt_c + 1;
    end else rd_data_c <= 64'h0BAD_0BAD_0BAD_0BAD;
  end

  // Common view of whichever DUT is under test
  logic        rdy = 1'b0;
  logic        v_valid, v_rd_en, v_done;
  logic [63:0] v_data;
  logic [31:0] v_index;
  logic [1:0]  v_core;
  int          v_rd_cnt;

  always_comb begin
    v_valid = valid_a; v_rd_en = rd_en_a; v_done = done_a; v_data = data_a;
    v_index = index_a; v_core = {1'b0, core_a}; v_rd_cnt = rd_cnt_a;
    if (dsel == 1) begin
      v_valid = valid_b; v_rd_en = rd_en_b; v_done = done_b; v_data = data_b;
      v_index = index_b; v_core = core_b; v_rd_cnt = rd_cnt_b;
    end else if (dsel == 2) begin
      v_valid = valid_c; v_rd_en = rd_en_c; v_done = done_c; v_data = data_c;
      v_index = index_c; v_core = {1'b0, core_c}; v_rd_cnt = rd_cnt_c;
    end
  end

  assign ready_a = rdy && (dsel == 0);
  assign ready_b = rdy && (dsel == 1);
  assign ready_c = rdy && (dsel == 2);

  task automatic consume(input int core, input int words, input int stall_idx);
    for (int w = 0; w < words; w++) begin
      int t = 0;
      while (!v_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("valid c%0d w%0d", core, w), 64'(v_valid), 64'd1);
      if (!v_valid) return;
      check($sformatf("core c%0d w%0d", core, w), 64'(v_core), 64'(core));
      check($sformatf("index c%0d w%0d", core, w), 64'(v_index), 64'(w));
      check($sformatf("data c%0d w%0d", core, w), v_data, mem_word(core, w));
      if (w == stall_idx) begin
        for (int s = 1; s < 7; s++) begin
          @(negedge clk);
          check("stall_valid", 64'(v_valid), 64'd1);
          check("stall_index", 64'(v_index), 64'(w));
          check("stall_data", v_data, mem_word(core, w));
          check("stall_no_rd", 64'(v_rd_en), 64'd0);
        end
      end
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
      check("valid_drop", 64'(v_valid), 64'd0);
    end
  endtask

  initial begin
    dsel = 0;
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    core_en_a = 1'b1; core_en_b = 4'b1011; core_en_c = 1'b1;
    inst_a = 32'h13; inst_b = {4{32'h13}}; inst_c = 32'h13;
    repeat (3) @(negedge clk);

    // Single core: 10 counted cycles, flush, 128-word dump with a stall on word 5
    reset_a = 1'b0;
    check("a_rst_cc", 64'(cc_a), 64'd0);
    check("a_rst_halted", 64'(halted_a), 64'd0);
    check("a_rst_rd", 64'(rd_en_a), 64'd0);
    check("a_rst_valid", 64'(valid_a), 64'd0);
    check("a_rst_done", 64'(done_a), 64'd0);
    repeat (10) @(negedge clk);
    check("a_cc_run", 64'(cc_a), 64'd10);
    check("a_not_halted", 64'(halted_a), 64'd0);
    inst_a = 32'h0;
    @(negedge clk);
    inst_a = 32'h13;
    check("a_cc_halt", 64'(cc_a), 64'd10);
    check("a_halted", 64'(halted_a), 64'd1);
    n = 0;
    while (!rd_en_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("a_first_rd_lat", 64'(n), 64'd6);
    rd0 = rd_cnt_a;
    consume(0, 128, 5);
    check("a_done", 64'(done_a), 64'd1);
    check("a_rd_total", 64'(rd_cnt_a - rd0), 64'd128);
    repeat (3) @(negedge clk);
    check("a_done_hold", 64'(done_a), 64'd1);
    check("a_cc_hold", 64'(cc_a), 64'd10);
    check("a_valid_done", 64'(valid_a), 64'd0);

    // Reset during OUT aborts and restarts counting
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    repeat (3) @(negedge clk);
    inst_a = 32'h0;
    @(negedge clk);
    inst_a = 32'h13;
    check("a2_cc", 64'(cc_a), 64'd3);
    n = 0;
    while (!valid_a && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("a2_valid", 64'(valid_a), 64'd1);
    reset_a = 1'b1;
    @(negedge clk);
    check("a2_rst_cc", 64'(cc_a), 64'd0);
    check("a2_rst_halted", 64'(halted_a), 64'd0);
    check("a2_rst_valid", 64'(valid_a), 64'd0);
    check("a2_rst_data", data_a, 64'd0);
    check("a2_rst_index", 64'(index_a), 64'd0);
    check("a2_rst_addr", 64'(addr_a), 64'd0);
    check("a2_rst_rd", 64'(rd_en_a), 64'd0);
    check("a2_rst_done", 64'(done_a), 64'd0);
    reset_a = 1'b0;
    repeat (2) @(negedge clk);
    check("a2_recount", 64'(cc_a), 64'd2);
    check("a2_rerun_halted", 64'(halted_a), 64'd0);

    // No core enabled: straight to done after the flush interval, no reads
    reset_a = 1'b1;
    core_en_a = 1'b0;
    @(negedge clk);
    reset_a = 1'b0;
    core_en_a = 1'b1;
    rd0 = rd_cnt_a;
    repeat (6) @(negedge clk);
    check("a3_done_early", 64'(done_a), 64'd0);
    @(negedge clk);
    check("a3_done", 64'(done_a), 64'd1);
    check("a3_halted", 64'(halted_a), 64'd1);
    check("a3_cc", 64'(cc_a), 64'd0);
    repeat (3) @(negedge clk);
    check("a3_no_rd", 64'(rd_cnt_a - rd0), 64'd0);

    // Four cores, core 2 disabled, halts at cycles 3, 20 and 8
    dsel = 1;
    reset_b = 1'b0;
    for (int k = 0; k < 25; k++) begin
      inst_b[31:0]   = (k >= 3)  ? 32'h0 : 32'h13;
      inst_b[63:32]  = (k >= 20) ? 32'h0 : 32'h13;
      inst_b[95:64]  = 32'h0;
      inst_b[127:96] = (k >= 8)  ? 32'h0 : 32'h13;
      @(negedge clk);
    end
    check("b_cc0", 64'(cc_b[31:0]), 64'd3);
    check("b_cc1", 64'(cc_b[63:32]), 64'd20);
    check("b_cc2", 64'(cc_b[95:64]), 64'd0);
    check("b_cc3", 64'(cc_b[127:96]), 64'd8);
    check("b_halted", 64'(halted_b), 64'hF);
    rd0 = rd_cnt_b;
    consume(0, 128, -1);
    consume(1, 128, -1);
    consume(3, 128, -1);
    check("b_done", 64'(done_b), 64'd1);
    check("b_rd_total", 64'(rd_cnt_b - rd0), 64'd384);
    check("b_cc1_hold", 64'(cc_b[63:32]), 64'd20);

    // Narrow counter saturates; zero flush interval
    dsel = 2;
    reset_c = 1'b0;
    repeat (30) @(negedge clk);
    inst_c = 32'h0;
    @(negedge clk);
    inst_c = 32'h13;
    check("c_cc_sat", 64'(cc_c), 64'd15);
    check("c_halted", 64'(halted_c), 64'd1);
    n = 0;
    while (!rd_en_c && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("c_first_rd_lat", 64'(n), 64'd1);
    rd0 = rd_cnt_c;
    consume(0, 4, -1);
    check("c_done", 64'(done_c), 64'd1);
    check("c_rd_total", 64'(rd_cnt_c - rd0), 64'd4);

    reset_c = 1'b1;
    core_en_c = 1'b0;
    @(negedge clk);
    reset_c = 1'b0;
    rd0 = rd_cnt_c;
    @(negedge clk);
    check("c2_done_early", 64'(done_c), 64'd0);
    @(negedge clk);
    check("c2_done", 64'(done_c), 64'd1);
    check("c2_no_rd", 64'(rd_cnt_c - rd0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
